// File: rtl/ps2_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ps2_pkg : shared constants, frame states and key-word field map |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_REL   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Keyboard status/acknowledge bytes that carry no key meaning on their own
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  localparam int KEY_TOGGLE  = 10;
  localparam int KEY_PRESSED = 9;
  localparam int KEY_EXT     = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  function automatic logic is_ignored_byte(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx_keyevent_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ps2_rx_keyevent_if : key-event and raw byte outputs             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface ps2_rx_keyevent_if;
  logic [10:0] ps2_key;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err;

  modport master (output ps2_key, byte_valid, byte_data, frame_err);
  modport slave  (input  ps2_key, byte_valid, byte_data, frame_err);
endinterface
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ps2_line_filter : 2-FF synchroniser, debouncer, falling edge     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic fall
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Idle PS/2 lines are pulled high, so reset to 1 to avoid a false edge
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], pin};
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        cnt   <= '0;
        level <= sync[1];
        fall  <= level & ~sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/ps2_rx_keyevent.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ps2_rx_keyevent : PS/2 frame receiver and scancode event decoder |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ps2_rx_keyevent
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  ps2_rx_keyevent_if.master evt
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic clk_fall, clk_level_unused, data_level, data_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk_sys(clk_sys), .reset(reset), .pin(ps2_clk),
    .level(clk_level_unused), .fall(clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk_sys(clk_sys), .reset(reset), .pin(ps2_data),
    .level(data_level), .fall(data_fall_unused)
  );

  frame_state_t  state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          byte_valid, frame_err;
  logic [7:0]    byte_data;
  logic          timeout;

  assign timeout = (state != ST_IDLE) && (tcnt == TW'(TIMEOUT_CYC));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == ST_IDLE || clk_fall) tcnt <= '0;
      else                              tcnt <= tcnt + 1'b1;
      // Timeout takes priority: a coincident fall is dropped, not taken as a start bit
      if (timeout) begin
        state     <= ST_IDLE;
        frame_err <= 1'b1;
        tcnt      <= '0;
      end else if (clk_fall) begin
        case (state)
          ST_IDLE: begin
            if (!data_level) begin
              state   <= ST_SHIFT;
              bit_cnt <= 3'd0;
            end
          end
          ST_SHIFT: begin
            shreg   <= {data_level, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= data_level;
            state   <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (data_level && ((^shreg) ^ par_bit)) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  logic        ext, rel;
  logic [2:0]  skip;
  logic [10:0] ps2_key;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ext     <= 1'b0;
      rel     <= 1'b0;
      skip    <= 3'd0;
      ps2_key <= 11'd0;
    end else if (frame_err) begin
      ext <= 1'b0;
      rel <= 1'b0;
    end else if (byte_valid) begin
      if (skip != 3'd0) begin
        skip <= skip - 3'd1;
      end else if (byte_data == PS2_PAUSE) begin
        skip <= PAUSE_SKIP;
      end else if (byte_data == PS2_EXT) begin
        ext <= 1'b1;
      end else if (byte_data == PS2_REL) begin
        rel <= 1'b1;
      end else if (ext || rel || !is_ignored_byte(byte_data)) begin
        ps2_key <= {~ps2_key[KEY_TOGGLE], ~rel, ext, byte_data};
        ext     <= 1'b0;
        rel     <= 1'b0;
      end
    end
  end

  assign evt.ps2_key    = ps2_key;
  assign evt.byte_valid = byte_valid;
  assign evt.byte_data  = byte_data;
  assign evt.frame_err  = frame_err;
endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_keyevent.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ps2_rx_keyevent : directed bench for the PS/2 key receiver    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_ps2_rx_keyevent;
  localparam int TO   = 2000;
  localparam int HALF = 20;
  localparam int GAP  = 60;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2c = 1'b1;
  logic ps2d = 1'b1;

  int checks = 0;
  int failures = 0;

  int cyc = 0, bv_cnt = 0, fe_cnt = 0, key_chg = 0, bv_cyc = 0, key_cyc = 0;
  logic [7:0]  last_byte = 8'h00;
  logic [10:0] prev_key = 11'd0;

  ps2_rx_keyevent_if evt ();

  ps2_rx_keyevent #(.FILTER_LEN(8), .TIMEOUT_CYC(TO)) dut (
    .clk_sys (clk),
    .reset   (reset),
    .ps2_clk (ps2c),
    .ps2_data(ps2d),
    .evt     (evt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (evt.byte_valid === 1'b1) begin
      bv_cnt    = bv_cnt + 1;
      last_byte = evt.byte_data;
      bv_cyc    = cyc;
    end
    if (evt.frame_err === 1'b1) fe_cnt = fe_cnt + 1;
    if (evt.ps2_key !== prev_key) begin
      key_chg  = key_chg + 1;
      key_cyc  = cyc;
      prev_key = evt.ps2_key;
    end
  end

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2d = bits[i];
      repeat (HALF) @(negedge clk);
      ps2c = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic good_par);
    logic p;
    p = ~^b;
    if (!good_par) p = ~p;
    send_bits({1'b1, p, b, 1'b0}, 11);
    repeat (GAP) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (evt.ps2_key !== 11'd0) begin failures++; $display("FAIL reset_key got=%h exp=000", evt.ps2_key); end
    checks++; if (evt.byte_valid !== 1'b0) begin failures++; $display("FAIL reset_bv got=%b exp=0", evt.byte_valid); end
    checks++; if (evt.frame_err !== 1'b0) begin failures++; $display("FAIL reset_fe got=%b exp=0", evt.frame_err); end
    checks++; if (evt.byte_data !== 8'h00) begin failures++; $display("FAIL reset_bd got=%h exp=00", evt.byte_data); end
  endtask

  task automatic test_make;
    int b0;
    b0 = bv_cnt;
    send_byte(8'h1C, 1'b1);
    checks++; if (bv_cnt - b0 !== 1) begin failures++; $display("FAIL make_bv_count got=%0d exp=1", bv_cnt - b0); end
    checks++; if (last_byte !== 8'h1C) begin failures++; $display("FAIL make_byte got=%h exp=1c", last_byte); end
    checks++; if (evt.ps2_key !== 11'h61C) begin failures++; $display("FAIL make_key got=%h exp=61c", evt.ps2_key); end
    checks++; if (key_cyc - bv_cyc !== 1) begin failures++; $display("FAIL make_latency got=%0d exp=1", key_cyc - bv_cyc); end
  endtask

  task automatic test_ext_release;
    int k0, b0;
    k0 = key_chg; b0 = bv_cnt;
    send_byte(8'hE0, 1'b1);
    send_byte(8'hF0, 1'b1);
    send_byte(8'h75, 1'b1);
    checks++; if (evt.ps2_key !== 11'h175) begin failures++; $display("FAIL ext_rel_key got=%h exp=175", evt.ps2_key); end
    checks++; if (key_chg - k0 !== 1) begin failures++; $display("FAIL ext_rel_events got=%0d exp=1", key_chg - k0); end
    checks++; if (bv_cnt - b0 !== 3) begin failures++; $display("FAIL ext_rel_bytes got=%0d exp=3", bv_cnt - b0); end
  endtask

  task automatic test_bad_parity;
    int f0, b0;
    f0 = fe_cnt; b0 = bv_cnt;
    send_byte(8'h1C, 1'b0);
    checks++; if (fe_cnt - f0 !== 1) begin failures++; $display("FAIL parity_fe got=%0d exp=1", fe_cnt - f0); end
    checks++; if (bv_cnt - b0 !== 0) begin failures++; $display("FAIL parity_bv got=%0d exp=0", bv_cnt - b0); end
    checks++; if (evt.ps2_key !== 11'h175) begin failures++; $display("FAIL parity_key_hold got=%h exp=175", evt.ps2_key); end
    send_byte(8'h1C, 1'b1);
    checks++; if (evt.ps2_key !== 11'h61C) begin failures++; $display("FAIL parity_recover got=%h exp=61c", evt.ps2_key); end
  endtask

  task automatic test_back_to_back;
    int k0;
    k0 = key_chg;
    send_byte(8'h1C, 1'b1);
    checks++; if (evt.ps2_key !== 11'h21C) begin failures++; $display("FAIL typematic_key got=%h exp=21c", evt.ps2_key); end
    checks++; if (key_chg - k0 !== 1) begin failures++; $display("FAIL typematic_events got=%0d exp=1", key_chg - k0); end
  endtask

  task automatic test_timeout;
    int f0, b0;
    logic p;
    f0 = fe_cnt; b0 = bv_cnt;
    p = ~^8'h29;
    send_bits({1'b1, p, 8'h29, 1'b0}, 6);
    repeat (TO + 100) @(negedge clk);
    checks++; if (fe_cnt - f0 !== 1) begin failures++; $display("FAIL timeout_fe got=%0d exp=1", fe_cnt - f0); end
    checks++; if (bv_cnt - b0 !== 0) begin failures++; $display("FAIL timeout_bv got=%0d exp=0", bv_cnt - b0); end
    checks++; if (evt.ps2_key !== 11'h21C) begin failures++; $display("FAIL timeout_key_hold got=%h exp=21c", evt.ps2_key); end
    send_byte(8'h29, 1'b1);
    checks++; if (evt.ps2_key !== 11'h629) begin failures++; $display("FAIL timeout_recover got=%h exp=629", evt.ps2_key); end
  endtask

  task automatic test_pause;
    int k0, b0;
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    k0 = key_chg; b0 = bv_cnt;
    for (int i = 0; i < 8; i++) send_byte(seq[i], 1'b1);
    checks++; if (key_chg - k0 !== 0) begin failures++; $display("FAIL pause_events got=%0d exp=0", key_chg - k0); end
    checks++; if (bv_cnt - b0 !== 8) begin failures++; $display("FAIL pause_bytes got=%0d exp=8", bv_cnt - b0); end
    checks++; if (evt.ps2_key !== 11'h629) begin failures++; $display("FAIL pause_key_hold got=%h exp=629", evt.ps2_key); end
    send_byte(8'h16, 1'b1);
    checks++; if (evt.ps2_key !== 11'h216) begin failures++; $display("FAIL pause_next got=%h exp=216", evt.ps2_key); end
  endtask

  task automatic test_reset_midframe;
    int f0, b0, k0;
    logic p;
    p = ~^8'h1C;
    send_bits({1'b1, p, 8'h1C, 1'b0}, 5);
    repeat (HALF) @(negedge clk);
    f0 = fe_cnt; b0 = bv_cnt;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (GAP) @(negedge clk);
    checks++; if (evt.ps2_key !== 11'd0) begin failures++; $display("FAIL midreset_key got=%h exp=000", evt.ps2_key); end
    checks++; if (bv_cnt - b0 !== 0) begin failures++; $display("FAIL midreset_bv got=%0d exp=0", bv_cnt - b0); end
    checks++; if (fe_cnt - f0 !== 0) begin failures++; $display("FAIL midreset_fe got=%0d exp=0", fe_cnt - f0); end
    k0 = key_chg; b0 = bv_cnt;
    send_byte(8'hAA, 1'b1);
    checks++; if (bv_cnt - b0 !== 1) begin failures++; $display("FAIL ignore_bv got=%0d exp=1", bv_cnt - b0); end
    checks++; if (key_chg - k0 !== 0) begin failures++; $display("FAIL ignore_events got=%0d exp=0", key_chg - k0); end
    send_byte(8'h1C, 1'b1);
    checks++; if (evt.ps2_key !== 11'h61C) begin failures++; $display("FAIL midreset_next got=%h exp=61c", evt.ps2_key); end
  endtask

  initial begin
    test_reset();
    test_make();
    test_ext_release();
    test_bad_parity();
    test_back_to_back();
    test_timeout();
    test_pause();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
